mixed_rx_unpacker: RTL and testbench

- Receive-side counterpart of the mixed data/address producer.
- Samples the producer's registered 16-bit data word, 8-bit address and its two status lines (valid, ready).
- Strips the zero pad byte, suppresses repeated (held) words, checks framing, and buffers payload/address pairs in a small FIFO.
- Presents the buffered pairs to a downstream consumer over a valid/ready handshake.

---
 rtl/mixed_pkg.sv | 25 ++
 rtl/mixed_rx_fifo.sv | 56 +++++
 rtl/mixed_rx_unpacker.sv | 103 ++++++++++
 tb/tb_mixed_rx_unpacker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mixed_pkg.sv
// Shared widths, field slices and the buffered entry layout for the mixed
// data/address receive path.
// Purely declarative: no logic, no clocking.
package mixed_pkg;

  localparam int DATA_W = 16;
  localparam int PAY_W  = 8;
  localparam int ADDR_W = 8;

  // Producer data word layout: payload byte on top, zero pad byte below.
  localparam int PAY_MSB = 15;
  localparam int PAY_LSB = 8;
  localparam int PAD_MSB = 7;
  localparam int PAD_LSB = 0;

  // One buffered pair as handed to the downstream consumer.
  typedef struct packed {
    logic [PAY_W-1:0]  payload;
    logic [ADDR_W-1:0] addr;
    logic              addr_vld;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/mixed_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head is read straight from storage.
// Latency: a push is visible at dout one cycle later; no input-to-output path.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active-high); push/din write side; pop/dout read side;
//        full, empty and level report occupancy.
module mixed_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head fields are never X.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (!do_push && do_pop) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/mixed_rx_unpacker.sv
// Receive side of the mixed data/address producer: strips the pad byte, drops held words, buffers pairs.
// Latency: a new word in cycle N is at the head (valid=1) in cycle N+1 when the FIFO was empty.
// Backpressure: valid/ready at the output; a new word arriving while full with no pop is dropped and flagged.
// Ports: clk/reset (sync, active-high); data_in/addr_in/valid_in/ready_in from the producer;
//        data_out/addr_out/addr_vld_out/valid with ready from the consumer;
//        fmt_err/overflow sticky flags cleared by clear_err; level is FIFO occupancy.
module mixed_rx_unpacker
  import mixed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DEDUP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     valid_in,
  input  logic                     ready_in,
  output logic [PAY_W-1:0]         data_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic                     addr_vld_out,
  output logic                     valid,
  input  logic                     ready,
  output logic                     fmt_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clear_err
);

  localparam int WORD_W = DATA_W + ADDR_W + 1;

  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] last_word;
  logic              last_vld;
  logic              is_new;
  logic              pop;
  logic              push;
  logic              drop;
  logic              bad_pad;
  logic              full;
  logic              empty;
  entry_t            wr_ent;
  entry_t            head_ent;

  // The producer holds its registered outputs between updates, so a word is
  // only new if it differs from the last one we accepted (or dedup is off).
  assign cur_word = {data_in, addr_in, ready_in};
  assign is_new   = valid_in & ((DEDUP == 0) | ~last_vld | (cur_word != last_word));
  assign pop      = valid & ready;
  assign push     = is_new & (~full | pop);
  assign drop     = is_new & full & ~pop;
  assign bad_pad  = is_new & (data_in[PAD_MSB:PAD_LSB] != '0);

  assign wr_ent.payload  = data_in[PAY_MSB:PAY_LSB];
  assign wr_ent.addr     = addr_in;
  assign wr_ent.addr_vld = ready_in;

  // Last word tracks every new word, pushed or dropped, so a dropped held
  // word is never retried.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_word <= '0;
      last_vld  <= 1'b0;
    end else if (is_new) begin
      last_word <= cur_word;
      last_vld  <= 1'b1;
    end
  end

  // Sticky flags: a set event in the same cycle as clear_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (bad_pad)        fmt_err <= 1'b1;
      else if (clear_err) fmt_err <= 1'b0;
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

  mixed_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (head_ent),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign valid        = ~empty;
  assign data_out     = head_ent.payload;
  assign addr_out     = head_ent.addr;
  assign addr_vld_out = head_ent.addr_vld;

endmodule

// File: tb/tb_mixed_rx_unpacker.sv
// Directed bench for mixed_rx_unpacker: a DEDUP=1 instance and a DEDUP=0
// instance share the same stimulus; expected values are hand-computed.
module tb_mixed_rx_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [7:0]  addr_in;
  logic        valid_in;
  logic        ready_in;
  logic        ready;
  logic        clear_err;

  logic [7:0]  data_out,  data_out0;
  logic [7:0]  addr_out,  addr_out0;
  logic        addr_vld_out, addr_vld_out0;
  logic        valid,     valid0;
  logic        fmt_err,   fmt_err0;
  logic        overflow,  overflow0;
  logic [2:0]  level,     level0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mixed_rx_unpacker #(.DEPTH(4), .DEDUP(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out),
    .addr_out(addr_out), .addr_vld_out(addr_vld_out), .valid(valid),
    .ready(ready), .fmt_err(fmt_err), .overflow(overflow), .level(level),
    .clear_err(clear_err)
  );

  mixed_rx_unpacker #(.DEPTH(4), .DEDUP(0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out0),
    .addr_out(addr_out0), .addr_vld_out(addr_vld_out0), .valid(valid0),
    .ready(ready), .fmt_err(fmt_err0), .overflow(overflow0), .level(level0),
    .clear_err(clear_err)
  );

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    valid_in = 1'b0;
    ready    = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = '0; addr_in = '0; valid_in = 1'b0;
    ready_in = 1'b0; ready = 1'b0; clear_err = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid",    valid,        0);
    chk("rst_level",    level,        0);
    chk("rst_data",     data_out,     0);
    chk("rst_addr",     addr_out,     0);
    chk("rst_addr_vld", addr_vld_out, 0);
    chk("rst_fmt",      fmt_err,      0);
    chk("rst_ovf",      overflow,     0);

    // Held word for 5 cycles: one entry only
    data_in = 16'hA500; addr_in = 8'h12; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    chk("hold_valid",    valid,        1);
    chk("hold_data",     data_out,     8'hA5);
    chk("hold_addr",     addr_out,     8'h12);
    chk("hold_addr_vld", addr_vld_out, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_level", level, 1);
    end
    chk("hold_fmt", fmt_err,  0);
    chk("hold_ovf", overflow, 0);

    // Six distinct words into a 4-deep FIFO with no pops
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      data_in = {8'(i), 8'h00}; addr_in = 8'(i); valid_in = 1'b1; ready_in = 1'b1;
      tick();
      chk("fill_level", level,    (i > 4) ? 4 : i);
      chk("fill_ovf",   overflow, (i >= 5) ? 1 : 0);
    end
    valid_in = 1'b0; ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", valid,    1);
      chk("drain_data",  data_out, k);
      chk("drain_addr",  addr_out, k);
      tick();
    end
    ready = 1'b0;
    chk("drain_empty", valid, 0);
    chk("drain_level", level, 0);

    // Framing error; overflow still set from above
    data_in = 16'h3C07; addr_in = 8'h33; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    chk("fmt_level", level,    1);
    chk("fmt_data",  data_out, 8'h3C);
    chk("fmt_set",   fmt_err,  1);
    data_in = 16'h4401; clear_err = 1'b1;
    tick();
    chk("fmt_clr_race",  fmt_err,  1);
    chk("ovf_cleared",   overflow, 0);
    chk("fmt_level2",    level,    2);
    valid_in = 1'b0;
    tick();
    chk("fmt_clr_alone", fmt_err,  0);
    clear_err = 1'b0;

    // Push while full with a simultaneous pop
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      data_in = {4'(i), 12'h000}; addr_in = 8'h40; valid_in = 1'b1; ready_in = 1'b1;
      tick();
    end
    chk("full_level", level, 4);
    data_in = 16'h5000; ready = 1'b1;
    tick();
    chk("fullpop_level", level,    4);
    chk("fullpop_ovf",   overflow, 0);
    valid_in = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk("fullpop_data", data_out, {4'(k), 4'h0});
      tick();
    end
    ready = 1'b0;
    chk("fullpop_empty", valid, 0);

    // Alternating A,B,A,B: all distinct from their predecessor
    do_reset();
    addr_in = 8'h55; ready_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = (i % 2 == 0) ? 16'h1100 : 16'h2200;
      tick();
    end
    chk("alt_level_dedup",   level,  4);
    chk("alt_level_nodedup", level0, 4);

    // Constant A for 4 cycles, then a gap, then A again
    do_reset();
    data_in = 16'h1100; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("const_level_dedup",   level,  1);
    chk("const_level_nodedup", level0, 4);
    valid_in = 1'b0;
    tick();
    valid_in = 1'b1;
    tick();
    chk("gap_level_dedup", level, 1);

    // Reset mid-stream with level=3, then re-present the held word
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      data_in = {4'h7, 4'(i), 8'h00}; addr_in = 8'h70; valid_in = 1'b1;
      tick();
    end
    chk("mid_level", level, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", valid, 0);
    chk("midrst_level", level, 0);
    tick();
    chk("midrst_new_level", level,    1);
    chk("midrst_new_data",  data_out, 8'h73);
    valid_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
